scene_ctrl: RTL and testbench

Scene sequencer and shared-image-ROM address controller for the VGA path. Owns the title/play/over scene state machine. Generates the single image-ROM read address for the 2×-upscaled 320×240 title and game-over images. Muxes ROM data against the game renderer's pixel stream and applies a per-frame fade-out/fade-in across scene changes. Sits between the VGA timing counters, the image block ROM, and the VGA output register.

---
 rtl/scene_ctrl_pkg.sv | 16 +
 rtl/scene_pixel_addr.sv | 32 +++
 rtl/scene_ctrl.sv | 115 +++++++++++
 tb/tb_scene_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scene_ctrl_pkg.sv
// scene_ctrl_pkg: scene codes, FSM states, image geometry and fade helpers
package scene_ctrl_pkg;
  typedef enum logic [1:0] {SCENE_TITLE = 2'd0, SCENE_PLAY = 2'd1, SCENE_OVER = 2'd2} scene_t;
  typedef enum logic [2:0] {S_TITLE, S_PLAY, S_OVER, S_FADE_OUT, S_FADE_IN} state_t;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_OVER_BASE = 76800;
  function automatic state_t steady_state(input scene_t s);
    return s == SCENE_PLAY ? S_PLAY : s == SCENE_OVER ? S_OVER : S_TITLE;
  endfunction
  function automatic logic [3:0] fade_ch(input logic [3:0] ch, input logic [4:0] lvl, input int sh);
    logic [8:0] p;
    p = 9'(ch) * 9'(lvl);
    return 4'(p >> sh);
  endfunction
endpackage

// File: rtl/scene_pixel_addr.sv
// scene_pixel_addr: registered image-ROM address for the 2x-upscaled title/over images
module scene_pixel_addr
  import scene_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int OVER_BASE = DEF_OVER_BASE,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  scene_t            scene,
  output logic [ADDR_W-1:0] rom_addr
);
  logic [9:0] col, row;
  logic [ADDR_W-1:0] base, addr;
  logic hit;
  always_comb begin
    col = h_cnt >> 1;
    row = v_cnt >> 1;
    base = scene == SCENE_OVER ? ADDR_W'(OVER_BASE) : '0;
    addr = base + ADDR_W'(col) + ADDR_W'(IMG_W) * ADDR_W'(row);
    hit = valid && scene != SCENE_PLAY && col < 10'(IMG_W) && row < 10'(IMG_H);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) rom_addr <= '0;
    else rom_addr <= hit ? addr : '0;
  end
endmodule

// File: rtl/scene_ctrl.sv
// scene_ctrl: title/play/over sequencer with image-ROM addressing and frame-stepped fade
module scene_ctrl
  import scene_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int OVER_BASE = DEF_OVER_BASE,
  parameter int ADDR_W = 18,
  parameter int FADE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              start_req,
  input  logic              over_req,
  input  logic              restart_req,
  input  logic [11:0]       rom_data,
  input  logic [11:0]       play_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [11:0]       vga_data,
  output logic              vga_valid,
  output logic [1:0]        scene,
  output logic              busy
);
  localparam int SH = $clog2(FADE_MAX);
  localparam logic [4:0] LVL_MAX = 5'(FADE_MAX);
  state_t state, state_nx;
  scene_t cur_scene, scene_nx, target, target_nx, scene_d1, scene_d2;
  logic pending, pending_nx, frame_tick, steady, req, valid_d1, valid_d2;
  logic [4:0] level, level_nx;
  logic [11:0] src, faded;
  scene_pixel_addr #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .OVER_BASE(OVER_BASE),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk(clk),
    .rst_n(rst_n),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .valid(valid),
    .scene(cur_scene),
    .rom_addr(rom_addr)
  );
  assign scene = cur_scene;
  assign busy = state == S_FADE_OUT || state == S_FADE_IN;
  always_comb begin
    frame_tick = h_cnt == 10'd0 && v_cnt == 10'd480;
    steady = state == S_TITLE || state == S_PLAY || state == S_OVER;
    req = steady && !pending && (state == S_TITLE ? start_req : state == S_PLAY ? over_req : restart_req);
    state_nx = state;
    scene_nx = cur_scene;
    target_nx = target;
    pending_nx = pending;
    level_nx = level;
    if (req) begin
      pending_nx = 1'b1;
      target_nx = state == S_TITLE ? SCENE_PLAY : state == S_PLAY ? SCENE_OVER : SCENE_TITLE;
    end
    if (frame_tick) begin
      if (steady && pending) begin
        state_nx = S_FADE_OUT;
        pending_nx = 1'b0;
      end else if (state == S_FADE_OUT) begin
        if (level == 5'd0) begin
          scene_nx = target;
          state_nx = S_FADE_IN;
        end else level_nx = level - 5'd1;
      end else if (state == S_FADE_IN) begin
        level_nx = level + 5'd1;
        if (level_nx == LVL_MAX) state_nx = steady_state(cur_scene);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_TITLE;
      cur_scene <= SCENE_TITLE;
      target <= SCENE_TITLE;
      pending <= 1'b0;
      level <= LVL_MAX;
    end else begin
      state <= state_nx;
      cur_scene <= scene_nx;
      target <= target_nx;
      pending <= pending_nx;
      level <= level_nx;
    end
  end
  // mux select trails the address path by two cycles so each pixel uses the scene it was addressed under
  always_comb begin
    src = scene_d2 == SCENE_PLAY ? play_data : rom_data;
    faded = level == LVL_MAX ? src : {fade_ch(src[11:8], level, SH), fade_ch(src[7:4], level, SH), fade_ch(src[3:0], level, SH)};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scene_d1 <= SCENE_TITLE;
      scene_d2 <= SCENE_TITLE;
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      vga_valid <= 1'b0;
      vga_data <= '0;
    end else begin
      scene_d1 <= cur_scene;
      scene_d2 <= scene_d1;
      valid_d1 <= valid;
      valid_d2 <= valid_d1;
      vga_valid <= valid_d2;
      vga_data <= valid_d2 ? faded : '0;
    end
  end
endmodule

// File: tb/tb_scene_ctrl.sv
// tb_scene_ctrl: randomized self-checking bench against a frame-timeline reference model
module tb_scene_ctrl;
  localparam int F = 4;
  typedef struct {
    int h;
    int v;
    bit val;
    int sc;
    logic [11:0] pd;
  } pix_t;
  logic clk = 0, rst_n = 0;
  logic [9:0] h_cnt = 0, v_cnt = 0;
  logic valid = 0, start_req = 0, over_req = 0, restart_req = 0;
  logic [11:0] rom_data = 0, play_data = 0;
  logic [17:0] rom_addr;
  logic [11:0] vga_data;
  logic vga_valid, busy;
  logic [1:0] scene;
  int checks = 0, failures = 0;
  int m_scene = 0, m_target = 0, m_pos = -1;
  bit m_pending = 0;
  pix_t hist[3];
  scene_ctrl #(.FADE_MAX(F)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .h_cnt(h_cnt),
    .v_cnt(v_cnt),
    .valid(valid),
    .start_req(start_req),
    .over_req(over_req),
    .restart_req(restart_req),
    .rom_data(rom_data),
    .play_data(play_data),
    .rom_addr(rom_addr),
    .vga_data(vga_data),
    .vga_valid(vga_valid),
    .scene(scene),
    .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] rom_fn(input int a);
    return 12'((a * 37) ^ (a >> 7));
  endfunction
  always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));
  function automatic int exp_addr(input pix_t p);
    if (!p.val || p.sc == 1) return 0;
    return (p.sc == 2 ? 76800 : 0) + p.h / 2 + 320 * (p.v / 2);
  endfunction
  function automatic int m_level();
    if (m_pos < 0) return F;
    return m_pos <= F ? F - m_pos : m_pos - F - 1;
  endfunction
  function automatic logic [11:0] fade(input logic [11:0] c, input int lv);
    if (lv == F) return c;
    return {4'(c[11:8] * lv / F), 4'(c[7:4] * lv / F), 4'(c[3:0] * lv / F)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int h, input int v, input bit s, input bit o, input bit r, input logic [11:0] pd);
    int lvl, sc_old, ea;
    bit tick, steady, pend_old, rst_now;
    logic [11:0] ev;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    valid = h < 640 && v < 480;
    start_req = s;
    over_req = o;
    restart_req = r;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{h, v, valid, m_scene, pd};
    play_data = hist[2].pd;
    lvl = m_level();
    sc_old = m_scene;
    rst_now = !rst_n;
    @(posedge clk);
    if (rst_now) begin
      m_scene = 0;
      m_target = 0;
      m_pos = -1;
      m_pending = 0;
      hist[0].val = 0;
      hist[1].val = 0;
      ea = 0;
      ev = 0;
    end else begin
      tick = h == 0 && v == 480;
      steady = m_pos < 0;
      pend_old = m_pending;
      if (tick && steady && pend_old) begin
        m_pos = 0;
        m_pending = 0;
      end else if (tick && !steady) begin
        m_pos++;
        if (m_pos == F + 1) m_scene = m_target;
        if (m_pos == 2 * F + 1) m_pos = -1;
      end
      if (steady && !pend_old) begin
        if (s && sc_old == 0) begin m_pending = 1; m_target = 1; end
        if (o && sc_old == 1) begin m_pending = 1; m_target = 2; end
        if (r && sc_old == 2) begin m_pending = 1; m_target = 0; end
      end
      ea = exp_addr(hist[0]);
      ev = hist[2].val ? fade(hist[2].sc == 1 ? hist[2].pd : rom_fn(exp_addr(hist[2])), lvl) : 12'h0;
    end
    #1;
    chk("addr", 32'(rom_addr), 32'(ea));
    chk("vga", 32'(vga_data), 32'(ev));
    chk("vvalid", 32'(vga_valid), 32'(!rst_now && hist[2].val));
    chk("scene", 32'(scene), 32'(m_scene));
    chk("busy", 32'(busy), 32'(m_pos >= 0));
  endtask
  task automatic rpix();
    int h, v;
    h = $urandom_range(0, 799);
    v = $urandom_range(0, 524);
    if (h == 0 && v == 480) v = 0;
    step(h, v, 0, 0, 0, 12'($urandom));
  endtask
  task automatic tick(input bit s, input bit o, input bit r);
    step(0, 480, s, o, r, 12'($urandom));
  endtask
  task automatic frame(input int n);
    repeat (n) rpix();
    tick(0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 12'h0};
    rst_n = 0;
    rpix();
    rpix();
    rst_n = 1;
    step(639, 479, 0, 0, 0, 12'h0);
    chk("addr_max", 32'(rom_addr), 32'd76799);
    chk("vv_rst1", 32'(vga_valid), 32'd0);
    step(100, 100, 0, 0, 0, 12'h0);
    chk("vv_rst2", 32'(vga_valid), 32'd0);
    step(101, 100, 0, 0, 0, 12'h0);
    chk("vv_on", 32'(vga_valid), 32'd1);
    step(5, 5, 0, 1, 1, 12'h0);
    frame(3);
    frame(3);
    chk("ign_scene", 32'(scene), 32'd0);
    chk("ign_busy", 32'(busy), 32'd0);
    step(5, 5, 1, 0, 0, 12'h0);
    chk("latch_only", 32'(busy), 32'd0);
    tick(0, 0, 0);
    chk("fade_t1", 32'(busy), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      repeat (4) rpix();
      if (k == 3) step(7, 7, 1, 0, 0, 12'h0);
      tick(0, 0, 0);
      chk($sformatf("scene_t%0d", k), 32'(scene), k >= 6 ? 32'd1 : 32'd0);
      chk($sformatf("busy_t%0d", k), 32'(busy), k < 10 ? 32'd1 : 32'd0);
    end
    frame(4);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_scene", 32'(scene), 32'd1);
    repeat (3) step(20, 20, 0, 0, 0, 12'hF84);
    chk("play_full", 32'(vga_data), 32'hF84);
    step(20, 20, 0, 1, 0, 12'hF84);
    repeat (3) tick(0, 0, 0);
    repeat (3) step(20, 20, 0, 0, 0, 12'hF84);
    chk("play_l2", 32'(vga_data), 32'h742);
    repeat (7) frame(2);
    chk("over_scene", 32'(scene), 32'd2);
    chk("over_busy", 32'(busy), 32'd0);
    step(2, 2, 0, 0, 0, 12'h0);
    chk("over_addr", 32'(rom_addr), 32'd77121);
    rpix();
    tick(0, 0, 1);
    chk("req_on_tick", 32'(busy), 32'd0);
    tick(0, 0, 0);
    chk("req_acted", 32'(busy), 32'd1);
    repeat (6) frame(2);
    chk("fin_scene", 32'(scene), 32'd0);
    chk("fin_busy", 32'(busy), 32'd1);
    rst_n = 0;
    step(30, 30, 0, 0, 0, 12'h0);
    rst_n = 1;
    chk("rst_scene", 32'(scene), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vga", 32'(vga_data), 32'd0);
    repeat (4) rpix();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 400) == 0) rst_n = 0;
      if ($urandom_range(0, 9) == 0) tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      else step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0), 12'($urandom));
      rst_n = 1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
